// File: rtl/execute_muldiv.sv
// -----------------------------------------------------------------------------
// execute_muldiv
//
// RISC-V M-extension execute unit. A request is presented in the execute stage
// and its result is handed to the memory stage as a one-cycle DoneM pulse.
// Multiplies complete after a fixed latency. Divides use a restoring radix-2
// iteration that produces one quotient bit per cycle, followed by one sign-fix
// cycle. Divide-by-zero and signed overflow bypass the iteration.
//
// Optional feature macro: MULDIV_DIV_EN
//   defined   : divider datapath and DIV_RUN/DIV_FIX states are built in;
//               IllegalM is always 0.
//   undefined : no divider logic. Divide/remainder ops finish on the fast path
//               with ResultM=0 and IllegalM=1.
//
// Latency is counted in cycles from the cycle in which ValidE is presented.
// That cycle ends with the accept edge. DoneM is high in cycle N:
//   multiply      : N = MUL_LATENCY (MUL_WAIT lasts MUL_LATENCY-1 cycles)
//   divide        : N = DATA_WIDTH+2 (DIV_RUN DATA_WIDTH cycles + DIV_FIX 1)
//   fast path     : N = 1 (the accept edge goes straight to DONE)
//
// Parameters
//   DATA_WIDTH  : operand/result width (even, 8..64)
//   MUL_LATENCY : multiply latency in cycles (1..4)
//
// Ports
//   clk       in   single clock, rising edge
//   rst       in   synchronous active-high reset
//   ValidE    in   start request
//   Funct3E   in   M-extension funct3
//   SrcAE     in   rs1 operand
//   SrcBE     in   rs2 operand
//   RdE       in   destination register tag
//   FlushE    in   abort any in-flight op and suppress a pending DoneM
//   BusyE     out  op in flight; stall request to the hazard unit
//   DoneM     out  one-cycle result-valid pulse
//   ResultM   out  result; holds its value between pulses
//   RdM       out  destination tag captured when the op was accepted
//   IllegalM  out  pulses with DoneM for a divide op when divide is compiled out
// -----------------------------------------------------------------------------
module execute_muldiv #(
    parameter int DATA_WIDTH  = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ValidE,
    input  logic [2:0]            Funct3E,
    input  logic [DATA_WIDTH-1:0] SrcAE,
    input  logic [DATA_WIDTH-1:0] SrcBE,
    input  logic [4:0]            RdE,
    input  logic                  FlushE,
    output logic                  BusyE,
    output logic                  DoneM,
    output logic [DATA_WIDTH-1:0] ResultM,
    output logic [4:0]            RdM,
    output logic                  IllegalM
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_MUL_WAIT = 3'd1;
`ifdef MULDIV_DIV_EN
    localparam logic [2:0] S_DIV_RUN  = 3'd2;
    localparam logic [2:0] S_DIV_FIX  = 3'd3;
`endif
    localparam logic [2:0] S_DONE     = 3'd4;

    localparam logic [DATA_WIDTH-1:0] ZERO_W = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] ONES_W = {DATA_WIDTH{1'b1}};

    // Control state
    logic [2:0]            stateR;
    logic [2:0]            nextStateS;
    logic [CNT_W-1:0]      cntR;
    logic [CNT_W-1:0]      cntNextS;
    logic                  nextBusyS;
    logic                  acceptS;

    // Captured request
    logic [DATA_WIDTH-1:0] aR;
    logic [DATA_WIDTH-1:0] bR;
    logic [1:0]            mulOpR;
    logic [4:0]            rdR;

    // Multiplier datapath
    logic [DATA_WIDTH-1:0]   mulAS;
    logic [DATA_WIDTH-1:0]   mulBS;
    logic [1:0]              mulOpS;
    logic                    mulSignAS;
    logic                    mulSignBS;
    logic [2*DATA_WIDTH-1:0] mulAExtS;
    logic [2*DATA_WIDTH-1:0] mulBExtS;
    logic [2*DATA_WIDTH-1:0] prodS;
    logic [DATA_WIDTH-1:0]   mulResultS;

    // Fast-path completion decided at the accept edge
    logic                  fastS;
    logic [DATA_WIDTH-1:0] fastResultS;
    logic                  fastIllegalS;

    // Values loaded into the output registers on entry to DONE
    logic [DATA_WIDTH-1:0] resultNextS;
    logic [4:0]            rdNextS;
    logic                  illegalNextS;

`ifdef MULDIV_DIV_EN
    // Divider datapath
    logic [DATA_WIDTH-1:0] remR;
    logic [DATA_WIDTH-1:0] quoR;
    logic [DATA_WIDTH-1:0] divisorR;
    logic                  negQR;
    logic                  negRR;
    logic                  divNegAS;
    logic                  divNegBS;
    logic                  divZeroS;
    logic                  divOvfS;
    logic [DATA_WIDTH:0]   divShiftS;
    logic [DATA_WIDTH:0]   divDiffS;
    logic [DATA_WIDTH-1:0] quoFixS;
    logic [DATA_WIDTH-1:0] remFixS;
    logic [DATA_WIDTH-1:0] divResultS;

    // Two's-complement negate when neg is set; used for |x| and the sign fix.
    function automatic logic [DATA_WIDTH-1:0] condNeg(
        input logic [DATA_WIDTH-1:0] v,
        input logic                  neg
    );
        if (neg) begin
            condNeg = ZERO_W - v;
        end else begin
            condNeg = v;
        end
    endfunction
`endif

    // Multiply: a single-cycle latency computes directly from the inputs at the
    // accept edge; longer latencies use the captured operands.
    always_comb begin
        acceptS = ValidE && !BusyE && !FlushE;
        if (MUL_LATENCY == 1) begin
            mulAS  = SrcAE;
            mulBS  = SrcBE;
            mulOpS = Funct3E[1:0];
        end else begin
            mulAS  = aR;
            mulBS  = bR;
            mulOpS = mulOpR;
        end
        // MULHU treats rs1 as unsigned; MULHSU and MULHU treat rs2 as unsigned.
        mulSignAS = (mulOpS != 2'b11);
        mulSignBS = (mulOpS == 2'b00) || (mulOpS == 2'b01);
        mulAExtS  = {{DATA_WIDTH{mulSignAS & mulAS[DATA_WIDTH-1]}}, mulAS};
        mulBExtS  = {{DATA_WIDTH{mulSignBS & mulBS[DATA_WIDTH-1]}}, mulBS};
        // The low 2*DATA_WIDTH bits of the extended product are exact.
        prodS     = mulAExtS * mulBExtS;
        if (mulOpS == 2'b00) begin
            mulResultS = prodS[DATA_WIDTH-1:0];
        end else begin
            mulResultS = prodS[2*DATA_WIDTH-1:DATA_WIDTH];
        end
    end

`ifdef MULDIV_DIV_EN
    // Divider combinational helpers: special-case detection, iteration step, sign fix.
    always_comb begin
        divNegAS = !Funct3E[0] && SrcAE[DATA_WIDTH-1];
        divNegBS = !Funct3E[0] && SrcBE[DATA_WIDTH-1];
        divZeroS = (SrcBE == ZERO_W);
        divOvfS  = !Funct3E[0] && (SrcAE == {1'b1, {(DATA_WIDTH-1){1'b0}}}) &&
                   (SrcBE == ONES_W);
        // Shift the next dividend bit into the partial remainder and trial-subtract.
        divShiftS  = {remR, quoR[DATA_WIDTH-1]};
        divDiffS   = divShiftS - {1'b0, divisorR};
        quoFixS    = condNeg(quoR, negQR);
        remFixS    = condNeg(remR, negRR);
        if (mulOpR[1]) begin
            divResultS = remFixS;
        end else begin
            divResultS = quoFixS;
        end
    end
`endif

    // Decide whether an accepted request completes on the fast path and what it returns.
    always_comb begin
`ifdef MULDIV_DIV_EN
        fastIllegalS = 1'b0;
        if (Funct3E[2]) begin
            fastS = divZeroS || divOvfS;
            if (divZeroS) begin
                fastResultS = Funct3E[1] ? SrcAE : ONES_W;
            end else if (divOvfS) begin
                fastResultS = Funct3E[1] ? ZERO_W : SrcAE;
            end else begin
                fastResultS = ZERO_W;
            end
        end else begin
            fastS       = (MUL_LATENCY == 1);
            fastResultS = mulResultS;
        end
`else
        if (Funct3E[2]) begin
            fastS        = 1'b1;
            fastResultS  = ZERO_W;
            fastIllegalS = 1'b1;
        end else begin
            fastS        = (MUL_LATENCY == 1);
            fastResultS  = mulResultS;
            fastIllegalS = 1'b0;
        end
`endif
    end

    // Next-state and iteration-counter logic.
    always_comb begin
        nextStateS = S_IDLE;
        cntNextS   = {CNT_W{1'b0}};
        case (stateR)
            S_IDLE, S_DONE: begin
                // acceptS already excludes FlushE, so a flush lands in IDLE here.
                if (acceptS) begin
                    if (fastS) begin
                        nextStateS = S_DONE;
                    end
`ifdef MULDIV_DIV_EN
                    else if (Funct3E[2]) begin
                        nextStateS = S_DIV_RUN;
                        cntNextS   = CNT_W'(DATA_WIDTH - 1);
                    end
`endif
                    else begin
                        nextStateS = S_MUL_WAIT;
                        cntNextS   = CNT_W'(MUL_LATENCY - 2);
                    end
                end else begin
                    nextStateS = S_IDLE;
                end
            end
            S_MUL_WAIT: begin
                if (FlushE) begin
                    nextStateS = S_IDLE;
                end else if (cntR == {CNT_W{1'b0}}) begin
                    nextStateS = S_DONE;
                end else begin
                    nextStateS = S_MUL_WAIT;
                    cntNextS   = cntR - CNT_W'(1);
                end
            end
`ifdef MULDIV_DIV_EN
            S_DIV_RUN: begin
                if (FlushE) begin
                    nextStateS = S_IDLE;
                end else if (cntR == {CNT_W{1'b0}}) begin
                    nextStateS = S_DIV_FIX;
                end else begin
                    nextStateS = S_DIV_RUN;
                    cntNextS   = cntR - CNT_W'(1);
                end
            end
            S_DIV_FIX: begin
                if (FlushE) begin
                    nextStateS = S_IDLE;
                end else begin
                    nextStateS = S_DONE;
                end
            end
`endif
            default: begin
                nextStateS = S_IDLE;
            end
        endcase
`ifdef MULDIV_DIV_EN
        nextBusyS = (nextStateS == S_MUL_WAIT) || (nextStateS == S_DIV_RUN) ||
                    (nextStateS == S_DIV_FIX);
`else
        nextBusyS = (nextStateS == S_MUL_WAIT);
`endif
    end

    // Select the result, tag and illegal flag that go out when DONE is entered.
    always_comb begin
        case (stateR)
            S_IDLE, S_DONE: begin
                resultNextS  = fastResultS;
                rdNextS      = RdE;
                illegalNextS = fastIllegalS;
            end
            S_MUL_WAIT: begin
                resultNextS  = mulResultS;
                rdNextS      = rdR;
                illegalNextS = 1'b0;
            end
`ifdef MULDIV_DIV_EN
            S_DIV_FIX: begin
                resultNextS  = divResultS;
                rdNextS      = rdR;
                illegalNextS = 1'b0;
            end
`endif
            default: begin
                resultNextS  = ZERO_W;
                rdNextS      = 5'd0;
                illegalNextS = 1'b0;
            end
        endcase
    end

    // Control state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateR   <= S_IDLE;
            cntR     <= {CNT_W{1'b0}};
            BusyE    <= 1'b0;
            DoneM    <= 1'b0;
            IllegalM <= 1'b0;
            ResultM  <= ZERO_W;
            RdM      <= 5'd0;
        end else begin
            stateR <= nextStateS;
            cntR   <= cntNextS;
            BusyE  <= nextBusyS;
            DoneM  <= (nextStateS == S_DONE);
            if (nextStateS == S_DONE) begin
                ResultM  <= resultNextS;
                RdM      <= rdNextS;
                IllegalM <= illegalNextS;
            end else begin
                IllegalM <= 1'b0;
            end
        end
    end

    // Request capture at the accept edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            aR     <= ZERO_W;
            bR     <= ZERO_W;
            mulOpR <= 2'b00;
            rdR    <= 5'd0;
        end else if (acceptS) begin
            aR     <= SrcAE;
            bR     <= SrcBE;
            mulOpR <= Funct3E[1:0];
            rdR    <= RdE;
        end
    end

`ifdef MULDIV_DIV_EN
    // Restoring divider: load magnitudes on accept, then one quotient bit per DIV_RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            remR     <= ZERO_W;
            quoR     <= ZERO_W;
            divisorR <= ZERO_W;
            negQR    <= 1'b0;
            negRR    <= 1'b0;
        end else if (acceptS) begin
            remR     <= ZERO_W;
            quoR     <= condNeg(SrcAE, divNegAS);
            divisorR <= condNeg(SrcBE, divNegBS);
            negQR    <= divNegAS ^ divNegBS;
            negRR    <= divNegAS;
        end else if (stateR == S_DIV_RUN) begin
            // Borrow out means the trial subtraction failed: keep the shifted value.
            if (divDiffS[DATA_WIDTH]) begin
                remR <= divShiftS[DATA_WIDTH-1:0];
            end else begin
                remR <= divDiffS[DATA_WIDTH-1:0];
            end
            quoR <= {quoR[DATA_WIDTH-2:0], !divDiffS[DATA_WIDTH]};
        end
    end
`endif

endmodule

// File: tb/tb_execute_muldiv.sv
// -----------------------------------------------------------------------------
// tb_execute_muldiv
//
// Directed bench for execute_muldiv (DATA_WIDTH=32, MUL_LATENCY=2). The stimulus
// process pushes the expected result, tag, illegal flag, completion cycle and
// busy-cycle count for every tracked request. A separate monitor pops an entry
// on each DoneM pulse and compares. Divide expectations follow MULDIV_DIV_EN.
// -----------------------------------------------------------------------------
module tb_execute_muldiv;

    localparam int DW = 32;
    localparam int ML = 2;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    logic          clk = 1'b0;
    logic          rst;
    logic          ValidE;
    logic [2:0]    Funct3E;
    logic [DW-1:0] SrcAE;
    logic [DW-1:0] SrcBE;
    logic [4:0]    RdE;
    logic          FlushE;
    logic          BusyE;
    logic          DoneM;
    logic [DW-1:0] ResultM;
    logic [4:0]    RdM;
    logic          IllegalM;

    typedef struct {
        logic [DW-1:0] res;
        logic [4:0]    rd;
        logic          ill;
        int            due;
        int            busy;
    } exp_t;

    exp_t sbQ[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    execute_muldiv #(.DATA_WIDTH(DW), .MUL_LATENCY(ML)) dut (
        .clk      (clk),
        .rst      (rst),
        .ValidE   (ValidE),
        .Funct3E  (Funct3E),
        .SrcAE    (SrcAE),
        .SrcBE    (SrcBE),
        .RdE      (RdE),
        .FlushE   (FlushE),
        .BusyE    (BusyE),
        .DoneM    (DoneM),
        .ResultM  (ResultM),
        .RdM      (RdM),
        .IllegalM (IllegalM)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Present one request for a single cycle. Call just after a rising edge.
    // lat = cycles from this issue cycle to DoneM; busy = BusyE cycles before DoneM.
    task automatic issue(input logic [2:0] f, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [4:0] rd, input bit track, input logic [DW-1:0] er,
                         input logic ill, input int lat, input int busy);
        exp_t e;
        ValidE  = 1'b1;
        Funct3E = f;
        SrcAE   = a;
        SrcBE   = b;
        RdE     = rd;
        if (track) begin
            e.res  = er;
            e.rd   = rd;
            e.ill  = ill;
            e.due  = cyc + lat;
            e.busy = busy;
            sbQ.push_back(e);
        end
        @(posedge clk);
        #1;
        ValidE = 1'b0;
        SrcAE  = 32'hDEADBEEF;
        SrcBE  = 32'h5A5A5A5A;
        RdE    = 5'd31;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compare every DoneM pulse against the scoreboard head.
    initial begin : monitor
        int   busyRun;
        exp_t e;
        busyRun = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busyRun = 0;
            end else if (DoneM) begin
                if (sbQ.size() == 0) begin
                    chk("spurious_done", 64'd1, 64'd0);
                end else begin
                    e = sbQ.pop_front();
                    chk("result", ResultM, e.res);
                    chk("rd", RdM, e.rd);
                    chk("illegal", IllegalM, e.ill);
                    chk("latency", cyc, e.due);
                    chk("busy_cycles", busyRun, e.busy);
                end
                busyRun = 0;
            end else begin
                chk("illegal_without_done", IllegalM, 64'd0);
                if (BusyE) begin
                    busyRun = busyRun + 1;
                end else begin
                    busyRun = 0;
                end
            end
        end
    end

    initial begin : stimulus
        rst     = 1'b1;
        ValidE  = 1'b0;
        FlushE  = 1'b0;
        Funct3E = 3'b000;
        SrcAE   = 32'h0;
        SrcBE   = 32'h0;
        RdE     = 5'd0;
        idle(3);
        rst = 1'b0;

        chk("reset_busy", BusyE, 64'd0);
        chk("reset_done", DoneM, 64'd0);
        chk("reset_result", ResultM, 64'd0);
        chk("reset_rd", RdM, 64'd0);
        chk("reset_illegal", IllegalM, 64'd0);

        // Multiplies
        issue(F_MUL,    32'd100,      32'hFFFFFFCE, 5'd5, 1'b1, 32'hFFFFEC78, 1'b0, ML, ML - 1);
        idle(3);
        issue(F_MULH,   32'h80000000, 32'h80000000, 5'd6, 1'b1, 32'h40000000, 1'b0, ML, ML - 1);
        idle(3);
        issue(F_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 1'b1, 32'hFFFFFFFE, 1'b0, ML, ML - 1);
        idle(3);
        issue(F_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, 1'b1, 32'hFFFFFFFF, 1'b0, ML, ML - 1);
        idle(3);
        issue(F_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9, 1'b1, 32'h00000001, 1'b0, ML, ML - 1);
        idle(3);

        // Back-to-back: second multiply issued in the DONE cycle of the first
        issue(F_MUL,   32'd7,        32'd6,        5'd10, 1'b1, 32'd42,       1'b0, ML, ML - 1);
        idle(ML - 1);
        issue(F_MULHU, 32'h00010000, 32'h00030000, 5'd11, 1'b1, 32'h00000003, 1'b0, ML, ML - 1);
        idle(3);

        // Request while busy must be ignored
        issue(F_MUL, 32'd12, 32'd12, 5'd12, 1'b1, 32'd144, 1'b0, ML, ML - 1);
        ValidE = 1'b1; Funct3E = F_MUL; SrcAE = 32'd9; SrcBE = 32'd9; RdE = 5'd2;
        idle(1);
        ValidE = 1'b0;
        idle(3);

        // Flush in MUL_WAIT with a simultaneous request: nothing accepted, no DoneM
        issue(F_MUL, 32'd3, 32'd4, 5'd13, 1'b0, 32'd0, 1'b0, 0, 0);
        FlushE = 1'b1; ValidE = 1'b1; Funct3E = F_MUL; SrcAE = 32'd2; SrcBE = 32'd2; RdE = 5'd3;
        idle(1);
        FlushE = 1'b0; ValidE = 1'b0;
        chk("flush_busy", BusyE, 64'd0);
        chk("flush_done", DoneM, 64'd0);
        idle(4);

        // Reset during a multiply
        issue(F_MUL, 32'd5, 32'd5, 5'd14, 1'b0, 32'd0, 1'b0, 0, 0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("rst_mul_busy", BusyE, 64'd0);
        chk("rst_mul_done", DoneM, 64'd0);
        chk("rst_mul_result", ResultM, 64'd0);
        chk("rst_mul_rd", RdM, 64'd0);
        chk("rst_mul_illegal", IllegalM, 64'd0);
        idle(4);

`ifdef MULDIV_DIV_EN
        issue(F_DIV,  32'hFFFFFF9C, 32'd7, 5'd15, 1'b1, 32'hFFFFFFF2, 1'b0, DW + 2, DW + 1);
        idle(DW + 4);
        issue(F_REM,  32'hFFFFFF9C, 32'd7, 5'd16, 1'b1, 32'hFFFFFFFE, 1'b0, DW + 2, DW + 1);
        idle(DW + 4);
        issue(F_DIVU, 32'd100,      32'd7, 5'd17, 1'b1, 32'd14,       1'b0, DW + 2, DW + 1);
        idle(DW + 4);
        issue(F_REMU, 32'd100,      32'd7, 5'd18, 1'b1, 32'd2,        1'b0, DW + 2, DW + 1);
        idle(DW + 4);
        issue(F_DIV,  32'd7, 32'hFFFFFFFE, 5'd19, 1'b1, 32'hFFFFFFFD, 1'b0, DW + 2, DW + 1);
        idle(DW + 4);
        issue(F_REM,  32'd7, 32'hFFFFFFFE, 5'd20, 1'b1, 32'd1,        1'b0, DW + 2, DW + 1);
        idle(DW + 4);
        // Fast paths, issued back-to-back in each DONE cycle
        issue(F_DIVU, 32'd5,        32'd0,        5'd21, 1'b1, 32'hFFFFFFFF, 1'b0, 1, 0);
        issue(F_REM,  32'd5,        32'd0,        5'd22, 1'b1, 32'd5,        1'b0, 1, 0);
        issue(F_DIV,  32'h80000000, 32'hFFFFFFFF, 5'd23, 1'b1, 32'h80000000, 1'b0, 1, 0);
        issue(F_REM,  32'h80000000, 32'hFFFFFFFF, 5'd24, 1'b1, 32'd0,        1'b0, 1, 0);
        idle(3);
        // Request during a divide is ignored
        issue(F_DIVU, 32'd1000, 32'd10, 5'd25, 1'b1, 32'd100, 1'b0, DW + 2, DW + 1);
        idle(4);
        ValidE = 1'b1; Funct3E = F_MUL; SrcAE = 32'd3; SrcBE = 32'd3; RdE = 5'd4;
        idle(1);
        ValidE = 1'b0;
        idle(DW + 2);
        // Flush in the 10th busy cycle of a divide
        issue(F_DIV, 32'd1000, 32'd3, 5'd26, 1'b0, 32'd0, 1'b0, 0, 0);
        idle(9);
        FlushE = 1'b1;
        idle(1);
        FlushE = 1'b0;
        chk("flush_div_busy", BusyE, 64'd0);
        chk("flush_div_done", DoneM, 64'd0);
        idle(DW + 4);
        // Reset mid-divide
        issue(F_DIV, 32'd1000, 32'd3, 5'd27, 1'b0, 32'd0, 1'b0, 0, 0);
        idle(5);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("rst_div_busy", BusyE, 64'd0);
        chk("rst_div_done", DoneM, 64'd0);
        chk("rst_div_result", ResultM, 64'd0);
        chk("rst_div_rd", RdM, 64'd0);
        chk("rst_div_illegal", IllegalM, 64'd0);
        idle(DW + 4);
`else
        // Divide compiled out: fast completion, zero result, IllegalM set
        issue(F_DIVU, 32'd9, 32'd3, 5'd15, 1'b1, 32'd0, 1'b1, 1, 0);
        idle(2);
        issue(F_REM,  32'd7, 32'd2, 5'd16, 1'b1, 32'd0, 1'b1, 1, 0);
        issue(F_DIV,  32'd8, 32'd0, 5'd17, 1'b1, 32'd0, 1'b1, 1, 0);
        issue(F_MUL,  32'd6, 32'd9, 5'd18, 1'b1, 32'd54, 1'b0, ML, ML - 1);
        idle(3);
        issue(F_REMU, 32'hFFFFFFFF, 32'd5, 5'd19, 1'b1, 32'd0, 1'b1, 1, 0);
        idle(3);
`endif

        for (int i = 0; i < 200 && sbQ.size() != 0; i++) begin
            @(posedge clk);
        end
        idle(2);
        chk("scoreboard_drained", sbQ.size(), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
